// File: rtl/mtx_pkg.sv
// Shared definitions for the Matrix datapath ingress buffer: CP register map,
// CP handshake states and drop counter width.
package mtx_pkg;

  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned CP_W       = 32;

  localparam logic [CP_W-1:0] REG_CH_EN     = 32'h0000_0000;
  localparam logic [CP_W-1:0] REG_FLUSH     = 32'h0000_0004;
  localparam logic [CP_W-1:0] REG_DROP_BASE = 32'h0000_0100;
  localparam logic [CP_W-1:0] REG_OCC_BASE  = 32'h0000_0200;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } cp_state_e;

  // True when addr falls in the 256-byte per-channel page starting at base.
  function automatic logic cp_in_page(input logic [CP_W-1:0] addr, input logic [CP_W-1:0] base);
    return addr[CP_W-1:8] == base[CP_W-1:8];
  endfunction

endpackage

// File: rtl/mtx_ch_fifo.sv
// Single-channel row-vector FIFO with synchronous flush and occupancy output.
module mtx_ch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = occ == OCC_W'(DEPTH);
  assign empty = occ == '0;
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mtx_dp_ingress_buf.sv
// Per-channel ingress buffer between external ingress and the MAPU array, with a
// control-plane slave for channel enable, flush, drop counters and occupancy.
module mtx_dp_ingress_buf
  import mtx_pkg::*;
#(
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned NUM_ROWS   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                          sys_clk,
  input  logic                                          sys_rst_n,
  input  logic [NUM_CH-1:0][NUM_ROWS-1:0][DATA_WIDTH-1:0] i_dp_ig_data,
  input  logic [NUM_CH-1:0]                             i_dp_ig_vld,
  output logic [NUM_CH-1:0]                             o_dp_ig_rdy,
  output logic [NUM_CH-1:0][NUM_ROWS-1:0][DATA_WIDTH-1:0] o_dp_eg_data,
  output logic [NUM_CH-1:0]                             o_dp_eg_vld,
  input  logic [NUM_CH-1:0]                             i_dp_eg_rdy,
  input  logic [CP_W-1:0]                               i_cp_addr,
  input  logic [CP_W-1:0]                               i_cp_wdata,
  output logic [CP_W-1:0]                               o_cp_rdata,
  input  logic                                          i_cp_vld,
  input  logic                                          i_cp_wr,
  output logic                                          o_cp_rdy,
  input  logic                                          test_mode_en
);

  localparam int unsigned WORD_W = NUM_ROWS * DATA_WIDTH;
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);

  cp_state_e              cp_state;
  logic [NUM_CH-1:0]      ch_en;
  logic [NUM_CH-1:0]      en;
  logic [NUM_CH-1:0]      full;
  logic [NUM_CH-1:0]      empty;
  logic [NUM_CH-1:0]      accept;
  logic [NUM_CH-1:0]      push;
  logic [NUM_CH-1:0]      drop_inc;
  logic [NUM_CH-1:0]      flush_vec;
  logic [NUM_CH-1:0]      drop_clr;
  logic [OCC_W-1:0]       occ [NUM_CH];
  logic [DROP_CNT_W-1:0]  drop_cnt [NUM_CH];
  logic                   cp_accept;
  logic                   cp_wr_acc;
  logic [5:0]             cp_idx;
  logic                   sel_ch_en;
  logic                   sel_flush;
  logic                   sel_drop;
  logic                   sel_occ;
  logic [CP_W-1:0]        rd_mux;
  logic                   unused_cp_bits;

  assign unused_cp_bits = ^{i_cp_addr[1:0], i_cp_wdata};

  // Disabled channels keep accepting so upstream never stalls; their beats are dropped.
  assign en          = ch_en | {NUM_CH{test_mode_en}};
  assign o_dp_ig_rdy = ~en | ~full;
  assign accept      = i_dp_ig_vld & o_dp_ig_rdy;
  assign push        = accept & en & ~flush_vec;
  assign drop_inc    = accept & (~en | flush_vec);
  assign o_dp_eg_vld = ~empty;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mtx_ch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
    ) u_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (push[c]),
      .pop   (o_dp_eg_vld[c] & i_dp_eg_rdy[c]),
      .flush (flush_vec[c]),
      .din   (i_dp_ig_data[c]),
      .dout  (o_dp_eg_data[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .occ   (occ[c])
    );
  end

  assign cp_idx    = i_cp_addr[7:2];
  assign sel_ch_en = i_cp_addr[CP_W-1:2] == REG_CH_EN[CP_W-1:2];
  assign sel_flush = i_cp_addr[CP_W-1:2] == REG_FLUSH[CP_W-1:2];
  assign sel_drop  = cp_in_page(i_cp_addr, REG_DROP_BASE);
  assign sel_occ   = cp_in_page(i_cp_addr, REG_OCC_BASE);
  assign cp_accept = (cp_state == IDLE) && i_cp_vld;
  assign cp_wr_acc = cp_accept && i_cp_wr;

  // Register decode: read mux plus write strobes for the accept cycle.
  always_comb begin
    rd_mux    = '0;
    flush_vec = '0;
    drop_clr  = '0;
    if (sel_ch_en) rd_mux = CP_W'(ch_en);
    if (cp_wr_acc && sel_flush) flush_vec = i_cp_wdata[NUM_CH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (cp_idx == 6'(c)) begin
        if (sel_drop) begin
          rd_mux      = CP_W'(drop_cnt[c]);
          drop_clr[c] = cp_wr_acc;
        end
        if (sel_occ) rd_mux = CP_W'(occ[c]);
      end
    end
  end

  // A clearing write wins over an increment in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ch_en <= '1;
      for (int c = 0; c < NUM_CH; c++) drop_cnt[c] <= '0;
    end else begin
      if (cp_wr_acc && sel_ch_en) ch_en <= i_cp_wdata[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (drop_clr[c]) begin
          drop_cnt[c] <= '0;
        end else if (drop_inc[c] && (drop_cnt[c] != '1)) begin
          drop_cnt[c] <= drop_cnt[c] + DROP_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cp_state   <= IDLE;
      o_cp_rdy   <= 1'b0;
      o_cp_rdata <= '0;
    end else begin
      case (cp_state)
        IDLE: begin
          o_cp_rdy   <= 1'b0;
          o_cp_rdata <= '0;
          if (i_cp_vld) begin
            cp_state   <= RESP;
            o_cp_rdy   <= 1'b1;
            o_cp_rdata <= i_cp_wr ? '0 : rd_mux;
          end
        end
        RESP: begin
          cp_state   <= IDLE;
          o_cp_rdy   <= 1'b0;
          o_cp_rdata <= '0;
        end
        default: begin
          cp_state   <= IDLE;
          o_cp_rdy   <= 1'b0;
          o_cp_rdata <= '0;
        end
      endcase
    end
  end

endmodule
